pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage PipeCPU. Drives the write-enable (`*_en`) and synchronous-clear (`*_flush`) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It covers load-use stalls, a multi-cycle multiply/divide busy window, branch/jump redirect flushes and external memory-wait freezes. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_cmp.sv | 17 +
 rtl/pipe_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the PipeCPU pipeline sequencing controller:
// the muldiv busy-window state, stall reason codes and the default latency.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [1:0] SR_NONE = 2'b00;
    localparam logic [1:0] SR_LU   = 2'b01;
    localparam logic [1:0] SR_MD   = 2'b10;
    localparam logic [1:0] SR_MW   = 2'b11;

    localparam int MULDIV_LAT_DEFAULT = 32;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load still sitting in EX. Kept separate so the forwarding
// unit can reuse the same register match.
module pipe_hazard_cmp (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rt,
    output logic       lu
);

    // Register zero is hardwired, so a load targeting it never creates a hazard.
    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs) || (id_use_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: drives enables and clears of the PC and
// pipe registers, tracks the HI/LO busy window of mult/div and counts
// stalled cycles for performance measurement.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rt,
    input  logic             id_hilo_use,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_muldiv_start,
    input  logic             mem_wait,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             muldiv_busy,
    output logic [1:0]       stall_reason,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [7:0]       CNT_LOAD = 8'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    md_state_t  state;
    md_state_t  state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       lu;
    logic       md;

    pipe_hazard_cmp u_hazard_cmp (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rt   (id_use_rt),
        .lu          (lu)
    );

    // An ID instruction touching HI/LO must wait out the busy window.
    assign md = (state == BUSY) && id_hilo_use;

    // The window is hidden while in reset because reset aborts it anyway.
    assign muldiv_busy = (state == BUSY) && !rst;

    // Busy-window next state: a frozen pipeline cannot issue a start, but the
    // countdown keeps running because the divider itself is not frozen.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (ex_muldiv_start && !mem_wait) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (ex_muldiv_start && !mem_wait) begin
                    cnt_next = CNT_LOAD;
                end else if (cnt == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Busy-window state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Enable/flush mux: memory wait freezes everything, a redirect kills the
    // two younger stages, and a hazard holds PC/IF-ID while inserting a bubble.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        stall_reason = SR_NONE;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_wait) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            stall_reason = SR_MW;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (md) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
            stall_reason = SR_MD;
        end else if (lu) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
            stall_reason = SR_LU;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: per-cycle vector table whose expected outputs are
// queued when driven and compared by a separate checker before each posedge.
module tb_pipe_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 4;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_BUB  = 5'b00111;
    localparam logic [2:0] FL_NONE = 3'b000;
    localparam logic [2:0] FL_RST  = 3'b111;
    localparam logic [2:0] FL_RED  = 3'b110;
    localparam logic [2:0] FL_BUB  = 3'b010;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       hilo;
        logic       mem_read;
        logic [4:0] rd;
        logic       redirect;
        logic       start;
        logic       mw;
        logic [4:0] en;
        logic [2:0] fl;
        logic       busy;
        logic [1:0] reason;
        int         stalls;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_use_rt;
    logic          id_hilo_use;
    logic          ex_mem_read;
    logic [4:0]    ex_rd;
    logic          ex_redirect;
    logic          ex_muldiv_start;
    logic          mem_wait;
    logic          pc_en;
    logic          ifid_en;
    logic          idex_en;
    logic          exmem_en;
    logic          memwb_en;
    logic          ifid_flush;
    logic          idex_flush;
    logic          exmem_flush;
    logic          muldiv_busy;
    logic [1:0]    stall_reason;
    logic [CW-1:0] stall_cycles;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pipe_ctrl #(
        .MULDIV_LAT (LAT),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rt       (id_use_rt),
        .id_hilo_use     (id_hilo_use),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_redirect     (ex_redirect),
        .ex_muldiv_start (ex_muldiv_start),
        .mem_wait        (mem_wait),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .muldiv_busy     (muldiv_busy),
        .stall_reason    (stall_reason),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(string name, logic r, logic [4:0] rs, logic [4:0] rt,
                                logic use_rt, logic hilo, logic mem_read, logic [4:0] rd,
                                logic redirect, logic start, logic mw, logic [4:0] en,
                                logic [2:0] fl, logic busy, logic [1:0] reason, int stalls);
        vec_t v;
        v.name = name; v.rst = r; v.rs = rs; v.rt = rt; v.use_rt = use_rt;
        v.hilo = hilo; v.mem_read = mem_read; v.rd = rd; v.redirect = redirect;
        v.start = start; v.mw = mw; v.en = en; v.fl = fl; v.busy = busy;
        v.reason = reason; v.stalls = stalls;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst             = v.rst;
        id_rs           = v.rs;
        id_rt           = v.rt;
        id_use_rt       = v.use_rt;
        id_hilo_use     = v.hilo;
        ex_mem_read     = v.mem_read;
        ex_rd           = v.rd;
        ex_redirect     = v.redirect;
        ex_muldiv_start = v.start;
        mem_wait        = v.mw;
        exp_q.push_back(v);
    endtask

    task automatic cmp(input string name, input string what, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s %s: got %b expected %b", name, what, got, want);
        end
    endtask

    task automatic checkOutput();
        vec_t v;
        v = exp_q.pop_front();
        cmp(v.name, "enables", {3'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {3'b0, v.en});
        cmp(v.name, "flushes", {5'b0, ifid_flush, idex_flush, exmem_flush}, {5'b0, v.fl});
        cmp(v.name, "muldiv_busy", {7'b0, muldiv_busy}, {7'b0, v.busy});
        cmp(v.name, "stall_reason", {6'b0, stall_reason}, {6'b0, v.reason});
        cmp(v.name, "stall_cycles", {4'b0, stall_cycles}, 8'(v.stalls));
    endtask

    // Checker: compares queued expectations against outputs settled before the posedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) checkOutput();
        end
    end

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_use_rt = 1'b0; id_hilo_use = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; ex_redirect = 1'b0; ex_muldiv_start = 1'b1;
        mem_wait = 1'b0;
        @(posedge clk);

        //   name               rst rs rt urt hl mr rd rdr st mw  en       fl       bsy rsn    cnt
        add("rst0",             1, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_RST,  0, 2'b00, 0);
        add("rst1",             1, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_RST,  0, 2'b00, 0);
        add("post_rst",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 0);
        add("lu_rs",            0, 5, 0, 0, 0, 1, 5, 0, 0, 0, EN_BUB,  FL_BUB,  0, 2'b01, 0);
        add("lu_clear",         0, 5, 0, 0, 0, 0, 5, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 1);
        add("lu_rt",            0, 3, 7, 1, 0, 1, 7, 0, 0, 0, EN_BUB,  FL_BUB,  0, 2'b01, 1);
        add("lu_rt_unused",     0, 3, 7, 0, 0, 1, 7, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 2);
        add("lu_rd0",           0, 0, 0, 1, 0, 1, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 2);
        add("no_load",          0, 5, 5, 1, 0, 0, 5, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 2);
        add("redir_over_lu",    0, 5, 0, 0, 0, 1, 5, 1, 0, 0, EN_ALL,  FL_RED,  0, 2'b00, 2);
        add("after_redir",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 2);
        add("md_start",         0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_ALL,  FL_NONE, 0, 2'b00, 2);
        add("md_stall1",        0, 0, 0, 0, 1, 0, 0, 0, 0, 0, EN_BUB,  FL_BUB,  1, 2'b10, 2);
        add("md_stall2",        0, 0, 0, 0, 1, 0, 0, 0, 0, 0, EN_BUB,  FL_BUB,  1, 2'b10, 3);
        add("md_over_lu",       0, 5, 0, 0, 1, 1, 5, 0, 0, 0, EN_BUB,  FL_BUB,  1, 2'b10, 4);
        add("md_stall4",        0, 0, 0, 0, 1, 0, 0, 0, 0, 0, EN_BUB,  FL_BUB,  1, 2'b10, 5);
        add("md_release",       0, 0, 0, 0, 1, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 6);
        add("md_start_redir",   0, 0, 0, 0, 0, 0, 0, 1, 1, 0, EN_ALL,  FL_RED,  0, 2'b00, 6);
        add("redir_over_md",    0, 0, 0, 0, 1, 0, 0, 1, 0, 0, EN_ALL,  FL_RED,  1, 2'b00, 6);
        add("mw1",              0, 0, 0, 0, 1, 0, 0, 1, 1, 1, EN_NONE, FL_NONE, 1, 2'b11, 6);
        add("mw2",              0, 0, 0, 0, 1, 0, 0, 1, 1, 1, EN_NONE, FL_NONE, 1, 2'b11, 7);
        add("mw3_last_busy",    0, 0, 0, 0, 1, 0, 0, 1, 1, 1, EN_NONE, FL_NONE, 1, 2'b11, 8);
        add("mw_drop",          0, 0, 0, 0, 1, 0, 0, 1, 1, 0, EN_ALL,  FL_RED,  0, 2'b00, 9);
        add("restart_busy",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 1, 2'b00, 9);
        add("reload_start",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_ALL,  FL_NONE, 1, 2'b00, 9);
        add("reload_b3",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 1, 2'b00, 9);
        add("reload_b2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 1, 2'b00, 9);
        add("reload_b1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 1, 2'b00, 9);
        add("reload_b0",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 1, 2'b00, 9);
        add("start_again",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_ALL,  FL_NONE, 0, 2'b00, 9);
        add("rst_mid_busy",     1, 0, 0, 0, 1, 0, 0, 0, 0, 0, EN_NONE, FL_RST,  0, 2'b00, 9);
        add("after_abort",      0, 0, 0, 0, 1, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 0);
        add("mw_over_lu",       0, 5, 0, 0, 0, 1, 5, 0, 0, 1, EN_NONE, FL_NONE, 0, 2'b11, 0);
        add("lu_after_mw",      0, 5, 0, 0, 0, 1, 5, 0, 0, 0, EN_BUB,  FL_BUB,  0, 2'b01, 1);
        add("idle",             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 2);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Saturation: twenty frozen cycles on a 4-bit counter, then hold at 15.
        vecs.delete();
        add("sat_rst",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_NONE, FL_RST,  0, 2'b00, 2);
        for (int k = 0; k < 20; k++) begin
            add($sformatf("sat_mw%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                EN_NONE, FL_NONE, 0, 2'b11, (k > 15) ? 15 : k);
        end
        add("sat_hold0",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 15);
        add("sat_hold1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 2'b00, 15);
        foreach (vecs[i]) applyStimulus(vecs[i]);

        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
